q_regulator: RTL

// Closed-loop Q regulator and next-generation measure/control/instability block. Counts pulses on the

---
 rtl/q_regulator.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/q_regulator.sv
// Closed-loop Q regulator: counts pulses per burst on q_serialized, averages 2^AVG_LOG2 bursts,
// steps i_ref_out toward q_desired, and halts when Q jumps without a matching i_ref change.
//   state  | meaning
//   IDLE   | loop stopped, waiting for start & enable
//   WAIT   | waiting for the first edge of a burst (timeout timer running)
//   COUNT  | counting edges until the idle watchdog expires
//   ACCUM  | add the burst sample to the accumulator
//   UPDATE | average, compare, step i_ref, instability test
//   HALT   | instability detected, outputs frozen until start
module q_regulator #(
  parameter int BUS_WIDTH         = 10,
  parameter int WTD_BUS_WIDTH     = 2,
  parameter int Q_PER_PULSE       = 30,
  parameter int TOL               = 1,
  parameter int I_REF_STEP        = 1,
  parameter int I_REF_INIT        = 0,
  parameter int AVG_LOG2          = 2,
  parameter int TIMEOUT           = 255,
  parameter int I_REF_DELTA_INSTB = 10,
  parameter int DELTA_Q_INSTB     = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 q_serialized,
  input  logic [BUS_WIDTH-1:0] q_desired,
  output logic [BUS_WIDTH-1:0] i_ref_out,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 converged,
  output logic                 unstable,
  output logic                 timeout,
  output logic                 busy
);

  localparam int ACC_W  = BUS_WIDTH + AVG_LOG2;
  localparam int PROD_W = BUS_WIDTH + $clog2(Q_PER_PULSE + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [BUS_WIDTH-1:0]     Q_MAX     = {BUS_WIDTH{1'b1}};
  localparam logic [WTD_BUS_WIDTH-1:0] IDLE_LOAD = {WTD_BUS_WIDTH{1'b1}};
  localparam logic [AVG_LOG2-1:0]      SAMP_LOAD = {AVG_LOG2{1'b1}};
  localparam logic [TMR_W-1:0]         TMR_LOAD  = TMR_W'(TIMEOUT - 1);
  localparam logic [BUS_WIDTH:0]       STEP_W    = (BUS_WIDTH + 1)'(I_REF_STEP);
  localparam logic [BUS_WIDTH:0]       TOL_W     = (BUS_WIDTH + 1)'(TOL);
  localparam logic [BUS_WIDTH-1:0]     DQ_W      = BUS_WIDTH'(DELTA_Q_INSTB);
  localparam logic [BUS_WIDTH-1:0]     DI_W      = BUS_WIDTH'(I_REF_DELTA_INSTB);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_COUNT, S_ACCUM, S_UPDATE, S_HALT} state_t;

  state_t                   state_q, state_d;
  logic                     sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic [WTD_BUS_WIDTH-1:0] idle_q, idle_d;
  logic [BUS_WIDTH-1:0]     edges_q, edges_d, sample_q, sample_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [AVG_LOG2-1:0]      samp_q, samp_d;
  logic                     first_q, first_d;
  logic [BUS_WIDTH-1:0]     prev_avg_q, prev_avg_d, prev_iref_q, prev_iref_d;
  logic [BUS_WIDTH-1:0]     i_ref_q, i_ref_d, q_meas_q, q_meas_d;
  logic                     conv_q, conv_d, unst_q, unst_d, tmo_q, tmo_d, busy_q, busy_d;

  logic                     edge_det;
  logic [PROD_W-1:0]        prod;
  logic [BUS_WIDTH-1:0]     avg, dq, di;
  logic signed [BUS_WIDTH:0] err;
  logic [BUS_WIDTH:0]       abs_err, i_up;
  logic                     in_tol;

  always_comb begin
    state_d     = state_q;
    sync1_d     = q_serialized;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    tmr_d       = tmr_q;
    idle_d      = idle_q;
    edges_d     = edges_q;
    sample_d    = sample_q;
    acc_d       = acc_q;
    samp_d      = samp_q;
    first_d     = first_q;
    prev_avg_d  = prev_avg_q;
    prev_iref_d = prev_iref_q;
    i_ref_d     = i_ref_q;
    q_meas_d    = q_meas_q;
    conv_d      = conv_q;
    unst_d      = unst_q;
    tmo_d       = tmo_q;

    edge_det = sync2_q & ~sync3_q;
    prod     = PROD_W'(edges_q) * PROD_W'(Q_PER_PULSE);
    avg      = acc_q[ACC_W-1:AVG_LOG2];
    err      = $signed({1'b0, q_desired}) - $signed({1'b0, avg});
    abs_err  = err[BUS_WIDTH] ? (BUS_WIDTH + 1)'(-err) : (BUS_WIDTH + 1)'(err);
    in_tol   = (abs_err <= TOL_W);
    dq       = (avg >= prev_avg_q) ? avg - prev_avg_q : prev_avg_q - avg;
    di       = (i_ref_q >= prev_iref_q) ? i_ref_q - prev_iref_q : prev_iref_q - i_ref_q;
    i_up     = {1'b0, i_ref_q} + STEP_W;

    case (state_q)
      S_IDLE, S_HALT: begin
        acc_d  = '0;
        samp_d = SAMP_LOAD;
        tmr_d  = TMR_LOAD;
        if (start && enable) begin
          state_d = S_WAIT;
          first_d = 1'b1;
          unst_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (edge_det) begin
          state_d = S_COUNT;
          edges_d = BUS_WIDTH'(1);
          idle_d  = IDLE_LOAD;
        end else if (tmr_q == '0) begin
          tmo_d    = 1'b1;
          sample_d = '0;
          state_d  = S_ACCUM;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_COUNT: begin
        if (edge_det && edges_q != Q_MAX) edges_d = edges_q + BUS_WIDTH'(1);
        // any high input, including one on the last idle cycle, keeps the burst alive
        if (sync2_q) begin
          idle_d = IDLE_LOAD;
        end else if (idle_q == '0) begin
          sample_d = (prod > PROD_W'(Q_MAX)) ? Q_MAX : prod[BUS_WIDTH-1:0];
          state_d  = S_ACCUM;
        end else begin
          idle_d = idle_q - WTD_BUS_WIDTH'(1);
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + ACC_W'(sample_q);
        tmr_d = TMR_LOAD;
        if (samp_q == '0) begin
          state_d = S_UPDATE;
        end else begin
          samp_d  = samp_q - AVG_LOG2'(1);
          state_d = S_WAIT;
        end
      end
      S_UPDATE: begin
        q_meas_d = avg;
        conv_d   = in_tol;
        samp_d   = SAMP_LOAD;
        if (!first_q && dq > DQ_W && di <= DI_W) begin
          unst_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          if (!in_tol && !err[BUS_WIDTH])
            i_ref_d = (i_up > {1'b0, Q_MAX}) ? Q_MAX : i_up[BUS_WIDTH-1:0];
          else if (!in_tol)
            i_ref_d = ({1'b0, i_ref_q} < STEP_W) ? '0 : i_ref_q - STEP_W[BUS_WIDTH-1:0];
          prev_avg_d  = avg;
          prev_iref_d = i_ref_q;
          acc_d       = '0;
          first_d     = 1'b0;
          state_d     = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d = S_IDLE;
      acc_d   = '0;
      samp_d  = SAMP_LOAD;
      tmr_d   = TMR_LOAD;
      edges_d = '0;
      idle_d  = IDLE_LOAD;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      tmr_q       <= '0;
      idle_q      <= '0;
      edges_q     <= '0;
      sample_q    <= '0;
      acc_q       <= '0;
      samp_q      <= '0;
      first_q     <= 1'b0;
      prev_avg_q  <= '0;
      prev_iref_q <= '0;
      i_ref_q     <= BUS_WIDTH'(I_REF_INIT);
      q_meas_q    <= '0;
      conv_q      <= 1'b0;
      unst_q      <= 1'b0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      tmr_q       <= tmr_d;
      idle_q      <= idle_d;
      edges_q     <= edges_d;
      sample_q    <= sample_d;
      acc_q       <= acc_d;
      samp_q      <= samp_d;
      first_q     <= first_d;
      prev_avg_q  <= prev_avg_d;
      prev_iref_q <= prev_iref_d;
      i_ref_q     <= i_ref_d;
      q_meas_q    <= q_meas_d;
      conv_q      <= conv_d;
      unst_q      <= unst_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
    end
  end

  assign i_ref_out  = i_ref_q;
  assign q_measured = q_meas_q;
  assign converged  = conv_q;
  assign unstable   = unst_q;
  assign timeout    = tmo_q;
  assign busy       = busy_q;

endmodule
